// File: rtl/long_op_scoreboard.sv
// Pending-write scoreboard for long-latency operations that complete out of order.
// It produces the ID-stage hold (RAW, WAW and capacity) and tracks the outstanding-operation count.
module long_op_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CW      = $clog2(MAX_OUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_wb_we,
    input  logic [4:0]      id_rd,
    input  logic            id_long,
    input  logic            flush,
    input  logic            cpl_valid,
    input  logic [4:0]      cpl_rd,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] pending,
    output logic [CW-1:0]   out_cnt,
    output logic            idle,
    output logic            err_cpl
);

    localparam logic [NREG-1:0] X0_MASK = ~NREG'(1);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            idle_q;
    logic            err_q;

    logic            rd_ok;
    logic            raw;
    logic            waw;
    logic            full;
    logic            hazard;
    logic            reserve;
    logic            cpl_hit;
    logic            cpl_bad;

    // ID-stage hazard detection against the registered scoreboard only
    always_comb begin
        rd_ok  = id_wb_we && (id_rd != 5'd0);
        raw    = (id_use_rs1 && pending_q[id_rs1]) || (id_use_rs2 && pending_q[id_rs2]);
        waw    = rd_ok && pending_q[id_rd];
        full   = id_long && rd_ok && (cnt_q == CW'(MAX_OUT));
        hazard = raw || waw || full;
        stall  = id_valid && !flush && hazard;
        issue  = id_valid && !flush && !hazard;
    end

    // Reservation on issue, release on a completion that matches a pending register
    always_comb begin
        reserve = issue && id_long && rd_ok;
        cpl_hit = cpl_valid && (cpl_rd != 5'd0) && pending_q[cpl_rd];
        cpl_bad = cpl_valid && !cpl_hit;

        set_vec = '0;
        clr_vec = '0;
        if (reserve) begin
            set_vec = (NREG'(1) << id_rd) & X0_MASK;
        end
        if (cpl_hit) begin
            clr_vec = NREG'(1) << cpl_rd;
        end
        pending_d = ((pending_q & ~clr_vec) | set_vec) & X0_MASK;
    end

    // A simultaneous issue and completion leaves the count unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (reserve && !cpl_hit) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!reserve && cpl_hit) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            idle_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            idle_q    <= (cnt_d == '0);
            if (cpl_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending = pending_q;
    assign out_cnt = cnt_q;
    assign idle    = idle_q;
    assign err_cpl = err_q;

endmodule

// File: tb/tb_long_op_scoreboard.sv
// Bench for long_op_scoreboard: directed scenarios with literal expectations, plus random traffic.
// All traffic is compared every cycle against a set-of-pending-registers model.
module tb_long_op_scoreboard;

    localparam int NREG    = 32;
    localparam int MAX_OUT = 4;
    localparam int CW      = $clog2(MAX_OUT + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic            id_use_rs1 = 1'b0;
    logic            id_use_rs2 = 1'b0;
    logic [4:0]      id_rs1 = '0;
    logic [4:0]      id_rs2 = '0;
    logic            id_wb_we = 1'b0;
    logic [4:0]      id_rd = '0;
    logic            id_long = 1'b0;
    logic            flush = 1'b0;
    logic            cpl_valid = 1'b0;
    logic [4:0]      cpl_rd = '0;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] pending;
    logic [CW-1:0]   out_cnt;
    logic            idle;
    logic            err_cpl;

    int checks   = 0;
    int failures = 0;

    bit m_pend [NREG];
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    long_op_scoreboard #(.NREG(NREG), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_wb_we   (id_wb_we),
        .id_rd      (id_rd),
        .id_long    (id_long),
        .flush      (flush),
        .cpl_valid  (cpl_valid),
        .cpl_rd     (cpl_rd),
        .stall      (stall),
        .issue      (issue),
        .pending    (pending),
        .out_cnt    (out_cnt),
        .idle       (idle),
        .err_cpl    (err_cpl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    // Compare against the model every cycle, then advance the model across the coming edge
    always @(negedge clk) begin
        logic [NREG-1:0] pv;
        bit rdok, hz, e_stall, e_issue;
        int cnt;
        cnt = m_cnt();
        for (int i = 0; i < NREG; i++) pv[i] = m_pend[i];
        rdok = id_wb_we && (id_rd != 5'd0);
        hz = (id_use_rs1 && m_pend[id_rs1]) || (id_use_rs2 && m_pend[id_rs2]) ||
             (rdok && m_pend[id_rd]) || (id_long && rdok && cnt == MAX_OUT);
        e_stall = id_valid && !flush && hz;
        e_issue = id_valid && !flush && !hz;
        chk("cyc_stall",   32'(stall),   32'(e_stall));
        chk("cyc_issue",   32'(issue),   32'(e_issue));
        chk("cyc_pending", 32'(pending), 32'(pv));
        chk("cyc_out_cnt", 32'(out_cnt), 32'(cnt));
        chk("cyc_idle",    32'(idle),    32'(cnt == 0));
        chk("cyc_err_cpl", 32'(err_cpl), 32'(m_err));
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            m_err = 1'b0;
        end else begin
            if (cpl_valid) begin
                if (cpl_rd != 5'd0 && m_pend[cpl_rd]) m_pend[cpl_rd] = 1'b0;
                else m_err = 1'b1;
            end
            if (e_issue && id_long && rdok) m_pend[id_rd] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input bit v, input bit u1, input int r1, input bit u2, input int r2,
                            input bit we, input int rd, input bit lg);
        id_valid   = v;
        id_use_rs1 = u1;
        id_rs1     = 5'(r1);
        id_use_rs2 = u2;
        id_rs2     = 5'(r2);
        id_wb_we   = we;
        id_rd      = 5'(rd);
        id_long    = lg;
    endtask

    task automatic no_id();
        drive_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int q[$];
        int regs3 [3] = '{3, 4, 6};

        step(); step();
        rst = 1'b0;
        #2;
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        chk("rst_idle",    32'(idle), 1);
        chk("rst_err_cpl", 32'(err_cpl), 0);
        chk("rst_issue",   32'(issue), 0);

        // Basic reservation and release
        step(); drive_id(1, 0, 0, 0, 0, 1, 5, 1); #2;
        chk("basic_issue", 32'(issue), 1);
        step(); drive_id(1, 1, 5, 0, 0, 1, 10, 0); cpl_valid = 1'b1; cpl_rd = 5'd5; #2;
        chk("basic_raw_stall", 32'(stall), 1);
        chk("basic_pend5",     32'(pending[5]), 1);
        chk("basic_out_cnt",   32'(out_cnt), 1);
        chk("model_cnt_one",   m_cnt(), 1);
        step(); cpl_valid = 1'b0; #2;
        chk("basic_cpl_stall", 32'(stall), 0);
        chk("basic_cpl_issue", 32'(issue), 1);
        chk("basic_cpl_idle",  32'(idle), 1);

        // Capacity
        for (int r = 1; r <= 4; r++) begin
            step(); drive_id(1, 0, 0, 0, 0, 1, r, 1); #2;
            chk("cap_fill_issue", 32'(issue), 1);
        end
        step(); drive_id(1, 0, 0, 0, 0, 1, 6, 1); #2;
        chk("cap_full_stall", 32'(stall), 1);
        chk("cap_full_cnt",   32'(out_cnt), 4);
        chk("model_cnt_four", m_cnt(), 4);
        step(); cpl_valid = 1'b1; cpl_rd = 5'd2; #2;
        chk("cap_stall_with_cpl", 32'(stall), 1);
        step(); cpl_valid = 1'b0; #2;
        chk("cap_issue_next", 32'(issue), 1);
        chk("cap_cnt_mid",    32'(out_cnt), 3);
        step(); no_id(); #2;
        chk("cap_cnt_after", 32'(out_cnt), 4);
        chk("cap_pending",   32'(pending), 32'h0000_005A);

        // Hazard filtering
        step(); drive_id(1, 0, 0, 0, 0, 1, 3, 0); #2;
        chk("waw_short_stall", 32'(stall), 1);
        step(); drive_id(1, 0, 3, 0, 0, 0, 0, 0); #2;
        chk("unused_rs1_issue", 32'(issue), 1);
        step(); drive_id(1, 0, 0, 0, 0, 1, 0, 1); #2;
        chk("rd0_long_issue", 32'(issue), 1);
        step(); no_id(); #2;
        chk("rd0_cnt",   32'(out_cnt), 4);
        chk("rd0_pend0", 32'(pending[0]), 0);

        for (int k = 0; k < 3; k++) begin
            step(); cpl_valid = 1'b1; cpl_rd = 5'(regs3[k]);
        end
        step(); cpl_valid = 1'b0; #2;
        chk("drain_pending", 32'(pending), 32'h0000_0002);
        chk("drain_cnt",     32'(out_cnt), 1);

        // Simultaneous issue and completion
        step(); drive_id(1, 0, 0, 0, 0, 1, 7, 1); cpl_valid = 1'b1; cpl_rd = 5'd1; #2;
        chk("simul_issue", 32'(issue), 1);
        step(); no_id(); cpl_valid = 1'b0; #2;
        chk("simul_pending", 32'(pending), 32'h0000_0080);
        chk("simul_cnt",     32'(out_cnt), 1);

        // Flush and spurious completion
        step(); drive_id(1, 1, 7, 0, 0, 1, 11, 0); #2;
        chk("flush_pre_stall", 32'(stall), 1);
        flush = 1'b1; #1;
        chk("flush_stall", 32'(stall), 0);
        chk("flush_issue", 32'(issue), 0);
        step(); flush = 1'b0; no_id(); #2;
        chk("flush_keeps_pend7", 32'(pending[7]), 1);
        step(); cpl_valid = 1'b1; cpl_rd = 5'd9;
        step(); cpl_valid = 1'b0; #2;
        chk("spurious_err",  32'(err_cpl), 1);
        chk("model_err_pin", 32'(m_err), 1);
        step(); step(); step(); #2;
        chk("err_sticky", 32'(err_cpl), 1);

        // Reset mid-operation
        step(); drive_id(1, 0, 0, 0, 0, 1, 8, 1);
        step(); drive_id(1, 0, 0, 0, 0, 1, 9, 1);
        step(); no_id(); #2;
        chk("pre_rst_cnt", 32'(out_cnt), 3);
        rst = 1'b1;
        step(); rst = 1'b0; #2;
        chk("midrst_pending", 32'(pending), 32'h0);
        chk("midrst_cnt",     32'(out_cnt), 0);
        chk("midrst_idle",    32'(idle), 1);
        chk("midrst_err",     32'(err_cpl), 0);

        // Random traffic
        repeat (3000) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            drive_id($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7),
                     1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 7), 1'($urandom));
            flush = ($urandom_range(0, 9) == 0);
            q.delete();
            for (int i = 1; i < NREG; i++) if (m_pend[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                cpl_valid = 1'b1;
                cpl_rd    = 5'(q[$urandom_range(0, q.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                cpl_valid = 1'b1;
                cpl_rd    = 5'($urandom_range(0, 31));
            end else begin
                cpl_valid = 1'b0;
            end
        end
        step(); rst = 1'b0; no_id(); flush = 1'b0; cpl_valid = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
